// File: rtl/ps2_keyboard_rx_if.sv
// rtl/ps2_keyboard_rx_if.sv - PS/2 pin and decoded-key signal bundle
// Purpose: groups the raw PS/2 pins with the decoded key outputs of ps2_keyboard_rx.
// Signals:
//   ps2_clk, ps2_data : raw PS/2 pins, asynchronous to the system clock
//   newKey            : one-cycle strobe, a make code was received
//   keyCode[7:0]      : last make code, held between strobes
//   extended          : last make code was E0-prefixed
//   frameErr          : one-cycle strobe, a frame was discarded
// Modports: master = receiver (drives key outputs), slave = consumer (drives pins).
interface ps2_keyboard_rx_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic       newKey;
   logic [7:0] keyCode;
   logic       extended;
   logic       frameErr;

   modport master (
      input  ps2_clk,
      input  ps2_data,
      output newKey,
      output keyCode,
      output extended,
      output frameErr
   );

   modport slave (
      output ps2_clk,
      output ps2_data,
      input  newKey,
      input  keyCode,
      input  extended,
      input  frameErr
   );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard frame receiver and make-code decoder
// Purpose: synchronizes and glitch-filters the PS/2 pins, deserializes 11-bit
//   device-to-host frames, strips E0/F0 prefixes and strobes newKey with the make code.
// Parameters:
//   FILTER_LEN     : equal synchronized ps2_clk samples needed to move the filtered clock (2..32)
//   TIMEOUT_CYCLES : clk cycles without a falling edge mid-frame before the frame is abandoned
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : ps2_keyboard_rx_if.master (pins in, newKey/keyCode/extended/frameErr out)
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_keyboard_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                clk,
   input  logic                reset,
   ps2_keyboard_rx_if.master   bus
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   // input conditioning
   logic                  ck_s1, ck_s2, dt_s1, dt_s2;
   logic [FILTER_LEN-1:0] ck_hist;
   logic                  ck_filt, ck_filt_nxt, fall;

   always_comb begin
      ck_filt_nxt = ck_filt;
      if (&ck_hist)
         ck_filt_nxt = 1'b1;
      else if (~|ck_hist)
         ck_filt_nxt = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ck_s1   <= 1'b1;
         ck_s2   <= 1'b1;
         dt_s1   <= 1'b1;
         dt_s2   <= 1'b1;
         ck_hist <= '1;
         ck_filt <= 1'b1;
         fall    <= 1'b0;
      end else begin
         ck_s1   <= bus.ps2_clk;
         ck_s2   <= ck_s1;
         dt_s1   <= bus.ps2_data;
         dt_s2   <= dt_s1;
         ck_hist <= {ck_hist[FILTER_LEN-2:0], ck_s2};
         ck_filt <= ck_filt_nxt;
         fall    <= ck_filt & ~ck_filt_nxt;
      end
   end

   // frame FSM and decoder state
   state_t        state, state_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    shreg, shreg_n;
   logic          par_bit, par_bit_n;
   logic          ext_pend, ext_pend_n, brk_pend, brk_pend_n;
   logic [TW-1:0] tmo_cnt, tmo_cnt_n;
   logic          new_key, new_key_n, frame_err, frame_err_n;
   logic [7:0]    key_code, key_code_n;
   logic          ext_q, ext_q_n;
   logic          frame_good;

   // dt_s2 holds the stop bit while the STOP-state fall is high
`ifdef PS2_PARITY_CHECK_EN
   assign frame_good = dt_s2 & (^{shreg, par_bit});
`else
   assign frame_good = dt_s2;
`endif

   always_comb begin
      state_n     = state;
      bit_cnt_n   = bit_cnt;
      shreg_n     = shreg;
      par_bit_n   = par_bit;
      ext_pend_n  = ext_pend;
      brk_pend_n  = brk_pend;
      key_code_n  = key_code;
      ext_q_n     = ext_q;
      new_key_n   = 1'b0;
      frame_err_n = 1'b0;

      if (state == S_IDLE || fall)
         tmo_cnt_n = '0;
      else
         tmo_cnt_n = tmo_cnt + TW'(1);

      case (state)
         S_IDLE: begin
            // a high bit here is a stray edge, not a start bit
            if (fall && !dt_s2) begin
               state_n   = S_DATA;
               bit_cnt_n = 3'd0;
            end
         end
         S_DATA: begin
            if (fall) begin
               shreg_n   = {dt_s2, shreg[7:1]};
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7)
                  state_n = S_PARITY;
            end
         end
         S_PARITY: begin
            if (fall) begin
               par_bit_n = dt_s2;
               state_n   = S_STOP;
            end
         end
         S_STOP: begin
            if (fall) begin
               state_n = S_IDLE;
               if (!frame_good) begin
                  frame_err_n = 1'b1;
                  ext_pend_n  = 1'b0;
                  brk_pend_n  = 1'b0;
               end else if (shreg == 8'hE0) begin
                  ext_pend_n = 1'b1;
               end else if (shreg == 8'hF0) begin
                  brk_pend_n = 1'b1;
               end else begin
                  if (!brk_pend) begin
                     new_key_n  = 1'b1;
                     key_code_n = shreg;
                     ext_q_n    = ext_pend;
                  end
                  ext_pend_n = 1'b0;
                  brk_pend_n = 1'b0;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase

      if (state != S_IDLE && !fall && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
         state_n     = S_IDLE;
         ext_pend_n  = 1'b0;
         brk_pend_n  = 1'b0;
         frame_err_n = 1'b1;
         tmo_cnt_n   = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         bit_cnt   <= 3'd0;
         shreg     <= 8'h00;
         par_bit   <= 1'b0;
         ext_pend  <= 1'b0;
         brk_pend  <= 1'b0;
         tmo_cnt   <= '0;
         new_key   <= 1'b0;
         frame_err <= 1'b0;
         key_code  <= 8'h00;
         ext_q     <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         shreg     <= shreg_n;
         par_bit   <= par_bit_n;
         ext_pend  <= ext_pend_n;
         brk_pend  <= brk_pend_n;
         tmo_cnt   <= tmo_cnt_n;
         new_key   <= new_key_n;
         frame_err <= frame_err_n;
         key_code  <= key_code_n;
         ext_q     <= ext_q_n;
      end
   end

   assign bus.newKey   = new_key;
   assign bus.keyCode  = key_code;
   assign bus.extended = ext_q;
   assign bus.frameErr = frame_err;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - self-checking bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;
   localparam int FILT = 8;
   localparam int TMO  = 500;
   localparam int HP   = 20;

   typedef struct packed {
      logic [1:0] kind;   // 0 newKey, 1 frameErr, 2 both strobes, 3 keyCode moved without newKey
      logic [7:0] code;
      logic       ext;
   } ev_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   ev_t  exp_q[$];
   ev_t  obs_q[$];
   logic [7:0] prev_kc = 8'h00;
   logic       prev_ext = 1'b0;

   ps2_keyboard_rx_if bus();

   ps2_keyboard_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   // event recorder only; comparisons happen in the test tasks
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.newKey && bus.frameErr)
            obs_q.push_back('{kind: 2'd2, code: bus.keyCode, ext: bus.extended});
         else if (bus.newKey)
            obs_q.push_back('{kind: 2'd0, code: bus.keyCode, ext: bus.extended});
         else if (bus.frameErr)
            obs_q.push_back('{kind: 2'd1, code: 8'h00, ext: 1'b0});
         if (!bus.newKey && (bus.keyCode !== prev_kc || bus.extended !== prev_ext))
            obs_q.push_back('{kind: 2'd3, code: bus.keyCode, ext: bus.extended});
      end
      prev_kc  = bus.keyCode;
      prev_ext = bus.extended;
   end

   task automatic send_bit(input logic b);
      bus.ps2_data = b;
      repeat (HP) @(posedge clk);
      bus.ps2_clk = 1'b0;
      repeat (HP) @(posedge clk);
      bus.ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop_b);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit((~^d) ^ flip_par);
      send_bit(stop_b);
      repeat (2 * HP) @(posedge clk);
   endtask

   task automatic key(input logic [7:0] d, input logic ext);
      exp_q.push_back('{kind: 2'd0, code: d, ext: ext});
   endtask

   task automatic test_reset;
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      reset = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (bus.newKey !== 1'b0) begin failures++; $display("FAIL reset_newKey: got %b, expected 0", bus.newKey); end
      checks++; if (bus.keyCode !== 8'h00) begin failures++; $display("FAIL reset_keyCode: got %h, expected 00", bus.keyCode); end
      checks++; if (bus.extended !== 1'b0) begin failures++; $display("FAIL reset_extended: got %b, expected 0", bus.extended); end
      checks++; if (bus.frameErr !== 1'b0) begin failures++; $display("FAIL reset_frameErr: got %b, expected 0", bus.frameErr); end
      reset = 1'b0;
      repeat (50) @(posedge clk);
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL reset_quiet: got %0d events, expected 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_single_frame;
      ev_t e, o;
      key(8'h1C, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b1);
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL single_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL single_event: got kind=%0d code=%h ext=%b, expected kind=%0d code=%h ext=%b", o.kind, o.code, o.ext, e.kind, e.code, e.ext); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_prefixes;
      ev_t e, o;
      key(8'h74, 1'b1);
      send_frame(8'hE0, 1'b0, 1'b1);
      send_frame(8'h74, 1'b0, 1'b1);
      send_frame(8'hE0, 1'b0, 1'b1);
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h74, 1'b0, 1'b1);
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL prefix_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL prefix_event: got kind=%0d code=%h ext=%b, expected kind=%0d code=%h ext=%b", o.kind, o.code, o.ext, e.kind, e.code, e.ext); end
      end
      checks++; if (bus.keyCode !== 8'h74 || bus.extended !== 1'b1) begin failures++; $display("FAIL prefix_hold: got %h/%b, expected 74/1", bus.keyCode, bus.extended); end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_parity;
      ev_t e, o;
`ifdef PS2_PARITY_CHECK_EN
      exp_q.push_back('{kind: 2'd1, code: 8'h00, ext: 1'b0});
`else
      key(8'h29, 1'b0);
`endif
      send_frame(8'h29, 1'b1, 1'b1);
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL parity_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL parity_event: got kind=%0d code=%h ext=%b, expected kind=%0d code=%h ext=%b", o.kind, o.code, o.ext, e.kind, e.code, e.ext); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_stop_error;
      ev_t e, o;
      exp_q.push_back('{kind: 2'd1, code: 8'h00, ext: 1'b0});
      send_frame(8'h1C, 1'b0, 1'b0);
      key(8'h1B, 1'b0);
      send_frame(8'h1B, 1'b0, 1'b1);
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL stop_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL stop_event: got kind=%0d code=%h ext=%b, expected kind=%0d code=%h ext=%b", o.kind, o.code, o.ext, e.kind, e.code, e.ext); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_timeout;
      ev_t e, o;
      exp_q.push_back('{kind: 2'd1, code: 8'h00, ext: 1'b0});
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      repeat (TMO + 10 + HP) @(posedge clk);
      key(8'h75, 1'b0);
      send_frame(8'h75, 1'b0, 1'b1);
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL timeout_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL timeout_event: got kind=%0d code=%h ext=%b, expected kind=%0d code=%h ext=%b", o.kind, o.code, o.ext, e.kind, e.code, e.ext); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid_frame;
      ev_t e, o;
      logic [7:0] d;
      d = 8'h5A;
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(d[i]);
      bus.ps2_data = d[5];
      repeat (5) @(posedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({bus.newKey, bus.keyCode, bus.extended, bus.frameErr} !== 11'd0) begin failures++; $display("FAIL midreset_outputs: got %b%h%b%b, expected all 0", bus.newKey, bus.keyCode, bus.extended, bus.frameErr); end
      reset = 1'b0;
      bus.ps2_data = 1'b1;
      repeat (20) @(posedge clk);
      exp_q.delete(); obs_q.delete();
      key(8'h6B, 1'b0);
      send_frame(8'h6B, 1'b0, 1'b1);
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL midreset_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL midreset_event: got kind=%0d code=%h ext=%b, expected kind=%0d code=%h ext=%b", o.kind, o.code, o.ext, e.kind, e.code, e.ext); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_glitch;
      ev_t e, o;
      // data low during the glitch: a glitch taken as a start bit would corrupt the next frame
      bus.ps2_data = 1'b0;
      repeat (5) @(posedge clk);
      bus.ps2_clk = 1'b0;
      repeat (2) @(posedge clk);
      bus.ps2_clk = 1'b1;
      repeat (5) @(posedge clk);
      bus.ps2_data = 1'b1;
      repeat (2 * HP) @(posedge clk);
      key(8'h1C, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b1);
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL glitch_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL glitch_event: got kind=%0d code=%h ext=%b, expected kind=%0d code=%h ext=%b", o.kind, o.code, o.ext, e.kind, e.code, e.ext); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_back_to_back;
      ev_t e, o;
      logic [7:0] seq [6];
      seq = '{8'hE0, 8'h75, 8'h6B, 8'hE0, 8'h6B, 8'h72};
      key(8'h75, 1'b1);
      key(8'h6B, 1'b0);
      key(8'h6B, 1'b1);
      key(8'h72, 1'b0);
      foreach (seq[i]) begin
         send_bit(1'b0);
         for (int b = 0; b < 8; b++) send_bit(seq[i][b]);
         send_bit(~^seq[i]);
         send_bit(1'b1);
      end
      repeat (2 * HP) @(posedge clk);
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL b2b_event: got kind=%0d code=%h ext=%b, expected kind=%0d code=%h ext=%b", o.kind, o.code, o.ext, e.kind, e.code, e.ext); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      test_reset;
      test_single_frame;
      test_prefixes;
      test_parity;
      test_stop_error;
      test_timeout;
      test_reset_mid_frame;
      test_glitch;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
